// File: rtl/alu_op_sequencer_if.sv
// ALU handshake bundle: operands, opcode and start toward the ALU; result and
// done strobe back from it.
interface alu_op_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 6
) ();
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_start;
    logic [DATA_W-1:0] alu_result;
    logic              alu_done;

    // Sequencer side
    modport master (
        output alu_a,
        output alu_b,
        output alu_op,
        output alu_start,
        input  alu_result,
        input  alu_done
    );

    // ALU side
    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_op,
        input  alu_start,
        output alu_result,
        output alu_done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Board-level ALU sequencer: debounces three buttons, captures operands and the
// opcode from the switches, fires a one-cycle start to the ALU, waits for done
// (with timeout) and shows the last good result on the LEDs.
module alu_op_sequencer #(
    parameter int unsigned DATA_W          = 8,  // must be >= OP_W
    parameter int unsigned OP_W            = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                CLK100MHZ,
    input  logic                i_reset,
    input  logic [DATA_W-1:0]   i_switch,
    input  logic [2:0]          i_btn,
    alu_op_sequencer_if.master  io_alu,
    output logic [DATA_W-1:0]   o_leds,
    output logic                o_busy,
    output logic                o_error
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TO_MAX = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'b100111);

    typedef enum logic [1:0] {StIdle, StExec, StWait} state_t;

    function automatic logic f_legal(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_SRL, OP_SRA, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR, OP_NOR: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic [2:0]        r_btn_s1, r_btn_s2;
    logic [DATA_W-1:0] r_sw_s1, r_sw_s2;
    logic [CNT_W-1:0]  r_db_cnt [3];
    logic [2:0]        r_db_level, r_db_prev;
    logic [2:0]        w_rise;
    logic              w_evt0, w_evt1, w_evt2;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt;
    logic [DATA_W-1:0] r_alu_b, w_alu_b_nxt;
    logic [OP_W-1:0]   r_alu_op, w_alu_op_nxt;
    logic              r_a_vld, w_a_vld_nxt;
    logic              r_b_vld, w_b_vld_nxt;
    logic [DATA_W-1:0] r_leds, w_leds_nxt;
    logic              r_error, w_error_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;

    // Two-flop synchronizers for the asynchronous buttons and switches
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= i_btn;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= i_switch;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Debouncers: level follows the synced input after DEBOUNCE_CYCLES equal samples
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            r_db_cnt   <= '{default: '0};
            r_db_level <= '0;
            r_db_prev  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                // Counting only while synced differs from the accepted level means any
                // return to that level restarts the run.
                if (r_btn_s2[k] == r_db_level[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_MAX) begin
                    r_db_level[k] <= r_btn_s2[k];
                    r_db_cnt[k]   <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
                end
            end
            r_db_prev <= r_db_level;
        end
    end

    // Press events with fixed priority btn0 > btn1 > btn2
    always_comb begin
        w_rise = r_db_level & ~r_db_prev;
        w_evt0 = w_rise[0];
        w_evt1 = w_rise[1] & ~w_rise[0];
        w_evt2 = w_rise[2] & ~w_rise[1] & ~w_rise[0];
    end

    // FSM and datapath register update
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_a_vld    <= 1'b0;
            r_b_vld    <= 1'b0;
            r_leds     <= '0;
            r_error    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_op   <= w_alu_op_nxt;
            r_a_vld    <= w_a_vld_nxt;
            r_b_vld    <= w_b_vld_nxt;
            r_leds     <= w_leds_nxt;
            r_error    <= w_error_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic; events are only acted on in IDLE, so operands hold while busy
    always_comb begin
        w_state_nxt    = r_state;
        w_alu_a_nxt    = r_alu_a;
        w_alu_b_nxt    = r_alu_b;
        w_alu_op_nxt   = r_alu_op;
        w_a_vld_nxt    = r_a_vld;
        w_b_vld_nxt    = r_b_vld;
        w_leds_nxt     = r_leds;
        w_error_nxt    = r_error;
        w_wait_cnt_nxt = r_wait_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_evt0) begin
                    w_alu_a_nxt = r_sw_s2;
                    w_a_vld_nxt = 1'b1;
                    w_error_nxt = 1'b0;
                end else if (w_evt1) begin
                    w_alu_b_nxt = r_sw_s2;
                    w_b_vld_nxt = 1'b1;
                    w_error_nxt = 1'b0;
                end else if (w_evt2) begin
                    w_alu_op_nxt = r_sw_s2[OP_W-1:0];
                    if (r_a_vld && r_b_vld && f_legal(r_sw_s2[OP_W-1:0])) begin
                        w_state_nxt = StExec;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            StExec: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = StWait;
            end
            StWait: begin
                // Done is checked first so it wins over a coincident timeout
                if (io_alu.alu_done) begin
                    w_leds_nxt  = io_alu.alu_result;
                    w_error_nxt = 1'b0;
                    w_state_nxt = StIdle;
                end else if (r_wait_cnt == TO_MAX) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign io_alu.alu_a     = r_alu_a;
    assign io_alu.alu_b     = r_alu_b;
    assign io_alu.alu_op    = r_alu_op;
    assign io_alu.alu_start = (r_state == StExec);
    assign o_leds           = r_leds;
    assign o_error          = r_error;
    assign o_busy           = (r_state != StIdle);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios followed by randomized button
// presses, all checked against an architectural model of operands/LEDs/error.
module tb_alu_op_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 6;
    localparam int unsigned DB = 4;
    localparam int unsigned TO = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sw    = '0;
    logic [2:0]    btn   = '0;
    logic [DW-1:0] leds;
    logic          busy;
    logic          error;

    alu_op_sequencer_if #(.DATA_W(DW), .OP_W(OW)) alu_if ();

    alu_op_sequencer #(
        .DATA_W          (DW),
        .OP_W            (OW),
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .CLK100MHZ (clk),
        .i_reset   (rst_n),
        .i_switch  (sw),
        .i_btn     (btn),
        .io_alu    (alu_if),
        .o_leds    (leds),
        .o_busy    (busy),
        .o_error   (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [5:0] legal_ops [8] = '{6'b000010, 6'b000011, 6'b100000, 6'b100010,
                                  6'b100100, 6'b100101, 6'b100110, 6'b100111};

    function automatic logic is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000010: return b >> a[2:0];
            6'b000011: return 8'($signed(b) >>> a[2:0]);
            default:   return 8'hEE;
        endcase
    endfunction

    // ALU stand-in: done arrives alu_delay cycles after the start cycle (0 = never);
    // result is random junk whenever done is low.
    int         alu_delay = 0;
    int         cd        = 0;
    logic       pend      = 1'b0;
    logic [7:0] pa, pb;
    logic [5:0] pop;
    int         start_cyc = 0;
    int         busy_cyc  = 0;

    always @(negedge clk) begin
        if (alu_if.alu_start) start_cyc <= start_cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        alu_if.alu_done   <= 1'b0;
        alu_if.alu_result <= 8'($urandom);
        if (alu_if.alu_start) begin
            if (alu_delay > 0) begin
                pend <= 1'b1;
                cd   <= alu_delay - 1;
                pa   <= alu_if.alu_a;
                pb   <= alu_if.alu_b;
                pop  <= alu_if.alu_op;
            end
        end else if (pend) begin
            if (cd == 0) begin
                alu_if.alu_done   <= 1'b1;
                alu_if.alu_result <= alu_fn(pa, pb, pop);
                pend              <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    // Architectural model
    logic [7:0] m_a, m_b, m_leds;
    logic [5:0] m_op;
    logic       m_av, m_bv, m_err;

    task automatic model_reset();
        m_a = '0; m_b = '0; m_leds = '0; m_op = '0;
        m_av = 1'b0; m_bv = 1'b0; m_err = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".a"},     32'(alu_if.alu_a),  32'(m_a));
        chk({tag, ".b"},     32'(alu_if.alu_b),  32'(m_b));
        chk({tag, ".op"},    32'(alu_if.alu_op), 32'(m_op));
        chk({tag, ".leds"},  32'(leds),          32'(m_leds));
        chk({tag, ".error"}, 32'(error),         32'(m_err));
        chk({tag, ".busy"},  32'(busy),          32'd0);
    endtask

    // Press from IDLE, hold long enough to debounce, release and let everything settle.
    task automatic press(input string tag, input logic [2:0] bits, input logic [7:0] swv,
                         input int delay);
        int s0, b0, exp_starts, exp_busy;
        alu_delay  = delay;
        sw         = swv;
        s0         = start_cyc;
        b0         = busy_cyc;
        exp_starts = 0;
        exp_busy   = 0;
        btn        = bits;
        tick(DB + 2);
        btn = '0;
        tick(30);
        if (bits[0]) begin
            m_a = swv; m_av = 1'b1; m_err = 1'b0;
        end else if (bits[1]) begin
            m_b = swv; m_bv = 1'b1; m_err = 1'b0;
        end else if (bits[2]) begin
            m_op = swv[5:0];
            if (m_av && m_bv && is_legal(m_op)) begin
                exp_starts = 1;
                if (delay >= 1 && delay <= int'(TO)) begin
                    m_leds   = alu_fn(m_a, m_b, m_op);
                    m_err    = 1'b0;
                    exp_busy = 1 + delay;
                end else begin
                    m_err    = 1'b1;
                    exp_busy = 1 + int'(TO);
                end
            end else begin
                m_err = 1'b1;
            end
        end
        chk({tag, ".starts"},    32'(start_cyc - s0), 32'(exp_starts));
        chk({tag, ".busy_cyc"},  32'(busy_cyc - b0),  32'(exp_busy));
        check_state(tag);
    endtask

    task automatic wait_busy(input string tag);
        int w;
        w = 0;
        while (!busy && w < 20) begin
            tick(1);
            w++;
        end
        chk({tag, ".busy_seen"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int         s0;
        logic [2:0] bits;
        logic [7:0] swv;
        int         delay;

        model_reset();

        // Reset held during random activity
        for (int i = 0; i < 6; i++) begin
            btn = 3'($urandom);
            sw  = 8'($urandom);
            tick(1);
        end
        chk("rst.start", 32'(alu_if.alu_start), 32'd0);
        check_state("rst");
        btn   = '0;
        rst_n = 1'b1;
        tick(10);
        check_state("post_rst");

        // Short glitch is filtered
        sw  = 8'h05;
        btn = 3'b001;
        tick(DB - 1);
        btn = '0;
        tick(12);
        check_state("glitch");

        press("loadA", 3'b001, 8'h05, 0);
        press("only_a", 3'b100, 8'b0010_0000, 3);
        press("loadB", 3'b010, 8'h03, 0);
        press("bad_op", 3'b100, 8'b0000_0001, 3);
        press("reloadA", 3'b001, 8'h05, 0);
        press("add_d3", 3'b100, 8'b0010_0000, 3);
        press("timeout", 3'b100, 8'b0010_0010, 0);
        press("done_at_to", 3'b100, 8'b0010_0010, 16);
        press("late_done", 3'b100, 8'b0010_0110, 17);
        press("best_case", 3'b100, 8'b0010_0000, 1);
        press("a_and_b", 3'b011, 8'h77, 0);

        // Press on btn0 while waiting on the ALU is dropped
        alu_delay = 0;
        sw        = 8'b0010_0000;
        btn       = 3'b100;
        tick(DB + 2);
        btn = '0;
        wait_busy("drop");
        sw  = 8'hC3;
        btn = 3'b001;
        tick(DB + 2);
        btn = '0;
        tick(30);
        m_op  = 6'b100000;
        m_err = 1'b1;
        check_state("drop");

        // Reset in the middle of WAIT; the later done must be ignored
        alu_delay = 8;
        sw        = 8'b0010_0100;
        btn       = 3'b100;
        tick(DB + 2);
        btn = '0;
        wait_busy("midrst");
        tick(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.start", 32'(alu_if.alu_start), 32'd0);
        check_state("midrst");
        tick(2);
        rst_n = 1'b1;
        s0    = start_cyc;
        tick(20);
        chk("midrst.starts", 32'(start_cyc - s0), 32'd0);
        check_state("midrst_after");

        // Randomized presses
        for (int i = 0; i < 40; i++) begin
            bits = 3'($urandom_range(1, 7));
            swv  = 8'($urandom);
            if ($urandom_range(0, 9) < 7) swv[5:0] = legal_ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0:       delay = 0;
                1:       delay = $urandom_range(14, 18);
                default: delay = $urandom_range(1, 8);
            endcase
            press("rand", bits, swv, delay);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
